// File: rtl/pong_disp_pkg.sv
// Shared definitions for the pong score display path: the BCD formatter's state
// encoding, its conversion geometry, and the default separator pattern.
package pong_disp_pkg;

    // Conversion geometry.
    localparam int SCORE_W    = 8;
    localparam int BCD_DIGITS = 3;
    localparam int DD_ITERS   = 8;

    // Working register width: BCD digits on top, the binary score underneath.
    localparam int DD_W       = SCORE_W + 4 * BCD_DIGITS;
    localparam int ITER_W     = $clog2(DD_ITERS);

    // Counter value at which the final shift happens.
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DD_ITERS - 1);

    // Two separator nibbles between the scores. All-ones leaves those display digits blank.
    localparam logic [7:0] SEP_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fmt_state_e;

    // Double-dabble digit correction. A digit of 5 or more would pass 9 after
    // the next shift, so add 3 first to make that shift carry into the next digit.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] i_nib);
        return (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    endfunction

endpackage

// File: rtl/dd_step.sv
// One double-dabble iteration for a single score. Each BCD nibble is corrected,
// then the whole register is shifted left by one bit. Purely combinational.
module dd_step
    import pong_disp_pkg::*;
(
    input  logic [DD_W-1:0] i_val,
    output logic [DD_W-1:0] o_val
);

    logic [DD_W-1:0] w_adj;

    // Correct each BCD nibble. The binary part in the low SCORE_W bits passes through unchanged.
    always_comb begin
        w_adj = i_val;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            w_adj[SCORE_W + 4*d +: 4] = add3_if_ge5(i_val[SCORE_W + 4*d +: 4]);
        end
    end

    assign o_val = {w_adj[DD_W-2:0], 1'b0};

endmodule

// File: rtl/score_bcd_formatter.sv
// Converts the two pong scores to packed BCD and builds the 32-bit word for
// the 8-digit display: {bcd_a, SEP, bcd_b}, with the leftmost digit in bits 31:28.
// Both scores are converted in parallel by iterative shift-and-add-3.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready high; wait for valid, then load the scores
// ST_SHIFT | one double-dabble step per cycle, 8 steps in total
// ST_DONE  | register the result into data_out and pulse done
module score_bcd_formatter
    import pong_disp_pkg::*;
#(
    parameter logic [7:0] SEP = SEP_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    output logic               ready,
    input  logic [SCORE_W-1:0] score_a,
    input  logic [SCORE_W-1:0] score_b,
    output logic [31:0]        data_out,
    output logic               done
);

    localparam logic [DD_W-SCORE_W-1:0] BCD_ZERO = '0;

    fmt_state_e        r_state;
    logic [ITER_W-1:0] r_iter;
    logic [DD_W-1:0]   r_a;
    logic [DD_W-1:0]   r_b;
    logic [31:0]       r_data;
    logic              r_done;

    logic [DD_W-1:0]   w_a_next;
    logic [DD_W-1:0]   w_b_next;

    dd_step u_step_a (
        .i_val (r_a),
        .o_val (w_a_next)
    );

    dd_step u_step_b (
        .i_val (r_b),
        .o_val (w_b_next)
    );

    // Sequence the conversion: load, shift 8 times, publish, return to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_iter  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= {12'h000, SEP, 12'h000};
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_a     <= {BCD_ZERO, score_a};
                        r_b     <= {BCD_ZERO, score_b};
                        r_iter  <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a    <= w_a_next;
                    r_b    <= w_b_next;
                    r_iter <= r_iter + ITER_W'(1);
                    // The counter wraps to 0 here. The state change, not the wrap, ends the shifting.
                    if (r_iter == ITER_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_data  <= {r_a[DD_W-1:SCORE_W], SEP, r_b[DD_W-1:SCORE_W]};
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ready is decoded from the state register, so it is free of input-to-output paths.
    assign ready    = (r_state == ST_IDLE);
    assign data_out = r_data;
    assign done     = r_done;

endmodule

// File: tb/tb_score_bcd_formatter.sv
module tb_score_bcd_formatter;

    logic        clk;
    logic        reset;
    logic        valid;
    logic        valid2;
    logic [7:0]  score_a;
    logic [7:0]  score_b;
    logic        ready;
    logic        ready2;
    logic        done;
    logic        done2;
    logic [31:0] data_out;
    logic [31:0] data_out2;

    int errors = 0;
    int checks = 0;

    score_bcd_formatter u_dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .ready    (ready),
        .score_a  (score_a),
        .score_b  (score_b),
        .data_out (data_out),
        .done     (done)
    );

    score_bcd_formatter #(.SEP(8'hAB)) u_sep (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid2),
        .ready    (ready2),
        .score_a  (score_a),
        .score_b  (score_b),
        .data_out (data_out2),
        .done     (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time limit: the directed sequence needs far fewer cycles than this.
    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Full transaction on the default instance. Nothing may pulse before edge E9.
    task automatic convert(input logic [7:0] a, input logic [7:0] b,
                           input logic [31:0] exp, input string tag);
        score_a = a;
        score_b = b;
        valid   = 1'b1;
        tick();                                   // E0
        valid = 1'b0;
        check({tag, "_busy"}, {31'd0, ready}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();                               // E1..E8
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        tick();                                   // E9
        check({tag, "_data"},  data_out, exp);
        check({tag, "_done"},  {31'd0, done},  32'd1);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        tick();
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, data_out, exp);
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        valid2  = 1'b0;
        score_a = 8'd0;
        score_b = 8'd0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_data",  data_out, 32'h000FF000);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_sep_data", data_out2, 32'h000AB000);

        convert(8'd12,  8'd7,   32'h012FF007, "basic");
        convert(8'd255, 8'd0,   32'h255FF000, "max_zero");
        convert(8'd99,  8'd100, 32'h099FF100, "99_100");
        convert(8'd0,   8'd255, 32'h000FF255, "zero_max");

        // Requests arriving while busy are dropped.
        score_a = 8'd3;
        score_b = 8'd4;
        valid   = 1'b1;
        tick();                                   // E0
        score_a = 8'd1;
        score_b = 8'd1;
        for (int i = 1; i <= 8; i++) begin
            tick();                               // E1..E8
            check("busy_ready", {31'd0, ready}, 32'd0);
            check("busy_nodone", {31'd0, done}, 32'd0);
        end
        valid = 1'b0;
        tick();                                   // E9
        check("busy_data", data_out, 32'h003FF004);
        check("busy_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("busy_no_second_done", {31'd0, done}, 32'd0);
            check("busy_hold", data_out, 32'h003FF004);
        end

        // Reset part-way through a conversion aborts it.
        score_a = 8'd50;
        score_b = 8'd60;
        valid   = 1'b1;
        tick();                                   // E0
        valid = 1'b0;
        tick();
        tick();
        tick();                                   // E3
        reset = 1'b1;
        tick();                                   // E4
        reset = 1'b0;
        check("abort_data",  data_out, 32'h000FF000);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        convert(8'd8, 8'd9, 32'h008FF009, "after_abort");

        // Reset and valid on the same edge: reset wins.
        score_a = 8'd77;
        score_b = 8'd88;
        reset   = 1'b1;
        valid   = 1'b1;
        tick();
        reset = 1'b0;
        valid = 1'b0;
        check("rst_valid_ready", {31'd0, ready}, 32'd1);
        check("rst_valid_data", data_out, 32'h000FF000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_valid_nodone", {31'd0, done}, 32'd0);
        end

        // Back-to-back requests with valid held high.
        score_a = 8'd10;
        score_b = 8'd20;
        valid   = 1'b1;
        tick();                                   // E0
        score_a = 8'd30;
        score_b = 8'd40;
        for (int i = 1; i <= 8; i++) begin
            tick();                               // E1..E8
            check("b2b_busy1", {31'd0, ready}, 32'd0);
        end
        tick();                                   // E9
        check("b2b_data1",  data_out, 32'h010FF020);
        check("b2b_done1",  {31'd0, done},  32'd1);
        check("b2b_ready1", {31'd0, ready}, 32'd1);
        tick();                                   // E10: second accept
        valid = 1'b0;
        check("b2b_accept2", {31'd0, ready}, 32'd0);
        check("b2b_done_drop", {31'd0, done}, 32'd0);
        for (int i = 11; i <= 18; i++) begin
            tick();                               // E11..E18
            check("b2b_nodone2", {31'd0, done}, 32'd0);
            check("b2b_hold1", data_out, 32'h010FF020);
        end
        tick();                                   // E19
        check("b2b_data2", data_out, 32'h030FF040);
        check("b2b_done2", {31'd0, done}, 32'd1);

        // Non-default separator.
        tick();
        score_a = 8'd5;
        score_b = 8'd6;
        valid2  = 1'b1;
        tick();                                   // E0
        valid2 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("sep_nodone", {31'd0, done2}, 32'd0);
        end
        tick();                                   // E9
        check("sep_data",  data_out2, 32'h005AB006);
        check("sep_done",  {31'd0, done2}, 32'd1);
        check("sep_ready", {31'd0, ready2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
